// File: rtl/reg_read_responder.sv
// Purpose: return path of the UART register bridge; reads N consecutive 32-bit registers and frames them as one UART packet.
// Latency: header byte valid 1 cycle after request acceptance, then one byte per cycle while ipTxReady is high.
// Backpressure: ipTxReady low freezes the presented byte and all framing fields; requests are refused while a packet is in flight.
//
// Ports:
//   ipClk, ipReset                 - clock, synchronous active-low reset
//   ipReqValid/opReqReady          - read request handshake (address, count, requester source)
//   opRdAddress/ipRdData           - register file read port, data valid one cycle after the address
//   opTx*                          - byte stream toward the UART packet transmitter (valid/ready)
//
// Build option: define READ_RESPONDER_CHECKSUM_EN to append an XOR checksum byte
// (covering the header and all data bytes) as the final byte of every packet.

module reg_read_responder #(
  parameter logic [7:0] LOCAL_ADDRESS = 8'h00,
  parameter int         BLOCK_WIDTH   = 32
) (
  input  logic                   ipClk,
  input  logic                   ipReset,

  input  logic                   ipReqValid,
  output logic                   opReqReady,
  input  logic [7:0]             ipReqAddress,
  input  logic [5:0]             ipReqCount,
  input  logic [7:0]             ipReqSource,

  output logic [7:0]             opRdAddress,
  input  logic [BLOCK_WIDTH-1:0] ipRdData,

  output logic [7:0]             opTxSource,
  output logic [7:0]             opTxDestination,
  output logic [7:0]             opTxLength,
  output logic [7:0]             opTxData,
  output logic                   opTxSoP,
  output logic                   opTxEoP,
  output logic                   opTxValid,
  input  logic                   ipTxReady
);

`ifdef READ_RESPONDER_CHECKSUM_EN
  localparam bit         CSUM_EN  = 1'b1;
  localparam logic [7:0] LEN_BASE = 8'd2;
`else
  localparam bit         CSUM_EN  = 1'b0;
  localparam logic [7:0] LEN_BASE = 8'd1;
`endif

  // ST_CSUM presents the trailing checksum byte and is only entered when the
  // checksum build option is enabled. ST_DONE is a one-cycle close-out for a
  // header-only packet; it can already accept the next request.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HEADER = 3'd1,
    ST_SEND   = 3'd2,
    ST_CSUM   = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  state_t state_q, state_d;

  // Datapath registers
  logic [7:0]             addr_q,    addr_d;     // start address, sent as header byte
  logic [7:0]             rd_addr_q, rd_addr_d;  // address of the word being prefetched
  logic [5:0]             words_q,   words_d;    // words still to be loaded into the shifter
  logic [1:0]             byte_q,    byte_d;     // byte position within the current word
  logic [BLOCK_WIDTH-1:0] shift_q,   shift_d;    // current word, MSB byte presented first
  logic [7:0]             len_q,     len_d;
  logic [7:0]             dest_q,    dest_d;
`ifdef READ_RESPONDER_CHECKSUM_EN
  logic [7:0]             csum_q,    csum_d;     // running XOR of all bytes sent so far
`endif

  logic accept_w;
  logic tx_hs_w;
  logic last_byte_w;
  logic more_words_w;

  // An edge with reset low is never an acceptance edge.
  assign accept_w     = ipReset & ipReqValid & opReqReady;
  assign tx_hs_w      = opTxValid & ipTxReady;
  assign last_byte_w  = (byte_q == 2'd3);
  // In HEADER this equals (count != 0); in SEND it means another word is pending.
  assign more_words_w = (words_q != 6'd0);

  //--------------------------------------------------------------------------
  // FSM: state register
  //--------------------------------------------------------------------------
  always_ff @(posedge ipClk) begin
    if (!ipReset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  //--------------------------------------------------------------------------
  // FSM: next-state logic
  //--------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = accept_w ? ST_HEADER : ST_IDLE;
      end
      ST_HEADER: begin
        if (tx_hs_w) begin
          if (more_words_w) begin
            state_d = ST_SEND;
          end else begin
            state_d = CSUM_EN ? ST_CSUM : ST_DONE;
          end
        end
      end
      ST_SEND: begin
        if (tx_hs_w && last_byte_w && !more_words_w) begin
          state_d = CSUM_EN ? ST_CSUM : ST_IDLE;
        end
      end
      ST_CSUM: begin
        if (tx_hs_w) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  //--------------------------------------------------------------------------
  // FSM: output logic
  //--------------------------------------------------------------------------
  always_comb begin
    opReqReady = 1'b0;
    opTxValid  = 1'b0;
    opTxData   = 8'h00;
    opTxSoP    = 1'b0;
    opTxEoP    = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        opReqReady = 1'b1;
      end
      ST_HEADER: begin
        opTxValid = 1'b1;
        opTxData  = addr_q;
        opTxSoP   = 1'b1;
        opTxEoP   = !CSUM_EN && !more_words_w;
      end
      ST_SEND: begin
        opTxValid = 1'b1;
        opTxData  = shift_q[BLOCK_WIDTH-1 -: 8];
        opTxEoP   = !CSUM_EN && last_byte_w && !more_words_w;
      end
      ST_CSUM: begin
        opTxValid = 1'b1;
`ifdef READ_RESPONDER_CHECKSUM_EN
        opTxData  = csum_q;
`endif
        opTxEoP   = 1'b1;
      end
      default: begin
        opReqReady = 1'b0;
      end
    endcase
  end

  // The start address is steered straight onto the read port in the
  // acceptance cycle so word 0 is already valid while the header is shown.
  assign opRdAddress     = accept_w ? ipReqAddress : rd_addr_q;
  assign opTxLength      = len_q;
  assign opTxDestination = dest_q;
  assign opTxSource      = LOCAL_ADDRESS;

  //--------------------------------------------------------------------------
  // Datapath next-state
  //--------------------------------------------------------------------------
  always_comb begin
    addr_d    = addr_q;
    rd_addr_d = rd_addr_q;
    words_d   = words_q;
    byte_d    = byte_q;
    shift_d   = shift_q;
    len_d     = len_q;
    dest_d    = dest_q;
`ifdef READ_RESPONDER_CHECKSUM_EN
    csum_d    = csum_q;
`endif

    if (accept_w) begin
      addr_d    = ipReqAddress;
      rd_addr_d = ipReqAddress;
      words_d   = ipReqCount;
      byte_d    = 2'd0;
      len_d     = {ipReqCount, 2'b00} + LEN_BASE;
      dest_d    = ipReqSource;
`ifdef READ_RESPONDER_CHECKSUM_EN
      csum_d    = ipReqAddress;
`endif
    end else if (tx_hs_w) begin
      if (state_q == ST_HEADER && more_words_w) begin
        // Word 0 was prefetched during acceptance; start fetching the next one.
        shift_d   = ipRdData;
        words_d   = words_q - 6'd1;
        rd_addr_d = rd_addr_q + 8'd1;
        byte_d    = 2'd0;
      end else if (state_q == ST_SEND) begin
`ifdef READ_RESPONDER_CHECKSUM_EN
        csum_d  = csum_q ^ shift_q[BLOCK_WIDTH-1 -: 8];
`endif
        shift_d = {shift_q[BLOCK_WIDTH-9:0], 8'h00};
        byte_d  = byte_q + 2'd1;
        if (last_byte_w && more_words_w) begin
          // The next word has been sitting on ipRdData for at least a byte
          // time, so it is loaded without a bubble. The 8-bit address wraps.
          shift_d   = ipRdData;
          words_d   = words_q - 6'd1;
          rd_addr_d = rd_addr_q + 8'd1;
        end
      end
    end
  end

  //--------------------------------------------------------------------------
  // Datapath registers
  //--------------------------------------------------------------------------
  always_ff @(posedge ipClk) begin
    if (!ipReset) begin
      addr_q    <= 8'h00;
      rd_addr_q <= 8'h00;
      words_q   <= 6'd0;
      byte_q    <= 2'd0;
      shift_q   <= '0;
      len_q     <= 8'h00;
      dest_q    <= 8'h00;
`ifdef READ_RESPONDER_CHECKSUM_EN
      csum_q    <= 8'h00;
`endif
    end else begin
      addr_q    <= addr_d;
      rd_addr_q <= rd_addr_d;
      words_q   <= words_d;
      byte_q    <= byte_d;
      shift_q   <= shift_d;
      len_q     <= len_d;
      dest_q    <= dest_d;
`ifdef READ_RESPONDER_CHECKSUM_EN
      csum_q    <= csum_d;
`endif
    end
  end

endmodule

// File: tb/tb_reg_read_responder.sv
// Purpose: self-checking bench for reg_read_responder (table vectors, random bursts, reset/busy/back-to-back sequences).
// Latency: expects the header byte one cycle after acceptance.
// Backpressure: drives ipTxReady constant-high or pseudo-random and checks stability while stalled.

module tb_reg_read_responder;

  localparam logic [7:0] LOC = 8'hA5;
`ifdef READ_RESPONDER_CHECKSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif

  logic        ipClk = 1'b0;
  logic        ipReset = 1'b0;
  logic        ipReqValid = 1'b0;
  logic [7:0]  ipReqAddress = 8'h00;
  logic [5:0]  ipReqCount = 6'd0;
  logic [7:0]  ipReqSource = 8'h00;
  logic        ipTxReady = 1'b1;
  logic        opReqReady;
  logic [7:0]  opRdAddress;
  logic [31:0] ipRdData;
  logic [7:0]  opTxSource, opTxDestination, opTxLength, opTxData;
  logic        opTxSoP, opTxEoP, opTxValid;

  logic [31:0] regs [256];
  assign ipRdData = regs[opRdAddress];

  reg_read_responder #(.LOCAL_ADDRESS(LOC), .BLOCK_WIDTH(32)) dut (
    .ipClk(ipClk), .ipReset(ipReset),
    .ipReqValid(ipReqValid), .opReqReady(opReqReady),
    .ipReqAddress(ipReqAddress), .ipReqCount(ipReqCount), .ipReqSource(ipReqSource),
    .opRdAddress(opRdAddress), .ipRdData(ipRdData),
    .opTxSource(opTxSource), .opTxDestination(opTxDestination), .opTxLength(opTxLength),
    .opTxData(opTxData), .opTxSoP(opTxSoP), .opTxEoP(opTxEoP), .opTxValid(opTxValid),
    .ipTxReady(ipTxReady)
  );

  always #5 ipClk = ~ipClk;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    logic [7:0] data;
    logic       sop;
    logic       eop;
    logic [7:0] len;
    logic [7:0] dest;
  } cap_t;

  cap_t       cap_q[$];
  logic [7:0] exp_q[$];
  int         eop_cnt = 0;
  bit         seen [256];
  bit         rnd_ready = 1'b0;

  logic       stall_prev = 1'b0;
  logic [7:0] st_data, st_len, st_dest;
  logic       st_sop, st_eop;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic bound_fail(input string name);
    n_assert++;
    n_fail++;
    $display("FAIL %s: cycle budget expired", name);
  endtask

  task automatic step();
    @(posedge ipClk);
    #1;
  endtask

  // Ready driver: changes only just after the active edge.
  initial begin
    forever begin
      @(posedge ipClk);
      #1;
      ipTxReady = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor on the falling edge: records accepted bytes, read addresses seen,
  // and checks that a stalled byte is held unchanged into the next cycle.
  always @(negedge ipClk) begin
    if (ipReset) begin
      seen[opRdAddress] = 1'b1;
      if (stall_prev) begin
        chk("stall_valid", 32'(opTxValid), 32'h1);
        chk("stall_data",  32'(opTxData),  32'(st_data));
        chk("stall_sop",   32'(opTxSoP),   32'(st_sop));
        chk("stall_eop",   32'(opTxEoP),   32'(st_eop));
        chk("stall_len",   32'(opTxLength), 32'(st_len));
        chk("stall_dest",  32'(opTxDestination), 32'(st_dest));
      end
      if (opTxValid && ipTxReady) begin
        cap_q.push_back('{opTxData, opTxSoP, opTxEoP, opTxLength, opTxDestination});
        if (opTxEoP) eop_cnt++;
      end
      stall_prev = opTxValid && !ipTxReady;
      st_data = opTxData;
      st_sop  = opTxSoP;
      st_eop  = opTxEoP;
      st_len  = opTxLength;
      st_dest = opTxDestination;
    end else begin
      stall_prev = 1'b0;
    end
  end

  // Reference packet: header, then words (a+k) mod 256 MSB first, then the
  // XOR of every preceding byte when the checksum option is built in.
  task automatic build_exp(input logic [7:0] a, input logic [5:0] c);
    logic [7:0]  x;
    logic [31:0] w;
    exp_q.delete();
    exp_q.push_back(a);
    x = a;
    for (int k = 0; k < int'(c); k++) begin
      w = regs[8'(int'(a) + k)];
      for (int b = 3; b >= 0; b--) begin
        exp_q.push_back(w[b*8 +: 8]);
        x = x ^ w[b*8 +: 8];
      end
    end
    if (CS == 1) exp_q.push_back(x);
  endtask

  task automatic start_pkt(input string tag, input logic [7:0] a, input logic [5:0] c,
                           input logic [7:0] s, input bit rnd);
    int t;
    rnd_ready = rnd;
    t = 0;
    while (!opReqReady && t < 3000) begin step(); t++; end
    if (!opReqReady) bound_fail({tag, "_wait_ready"});
    build_exp(a, c);
    cap_q.delete();
    eop_cnt = 0;
    foreach (seen[j]) seen[j] = 1'b0;
    ipReqAddress = a;
    ipReqCount   = c;
    ipReqSource  = s;
    ipReqValid   = 1'b1;
    step();
    ipReqValid   = 1'b0;
    chk({tag, "_hdr_valid"}, 32'(opTxValid), 32'h1);
    chk({tag, "_hdr_data"},  32'(opTxData),  32'(a));
    chk({tag, "_hdr_sop"},   32'(opTxSoP),   32'h1);
    chk({tag, "_hdr_busy"},  32'(opReqReady), 32'h0);
    chk({tag, "_src"},       32'(opTxSource), 32'(LOC));
  endtask

  task automatic finish_pkt(input string tag, input logic [5:0] c, input logic [7:0] s);
    int t;
    int n;
    t = 0;
    while (eop_cnt == 0 && t < 3000) begin step(); t++; end
    if (eop_cnt == 0) bound_fail({tag, "_wait_eop"});
    chk({tag, "_nbytes"}, 32'(cap_q.size()), 32'(exp_q.size()));
    n = (cap_q.size() < exp_q.size()) ? cap_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_byte%0d", tag, i), 32'(cap_q[i].data), 32'(exp_q[i]));
      chk($sformatf("%s_sop%0d", tag, i),  32'(cap_q[i].sop),  32'(i == 0));
      chk($sformatf("%s_eop%0d", tag, i),  32'(cap_q[i].eop),  32'(i == exp_q.size() - 1));
      chk($sformatf("%s_len%0d", tag, i),  32'(cap_q[i].len),  32'(1 + 4 * int'(c) + CS));
      chk($sformatf("%s_dst%0d", tag, i),  32'(cap_q[i].dest), 32'(s));
    end
  endtask

  typedef struct {
    logic [7:0] a;
    logic [5:0] c;
    logic [7:0] s;
    bit         rnd;
    logic [7:0] exp_len;
    bit         chk_last;
    logic [7:0] exp_last;
  } vec_t;

  vec_t vt [6];

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int j = 0; j < 256; j++) regs[j] = {8'(j), ~8'(j), 8'(j) ^ 8'h5A, 8'hC3};
    regs[8'h10] = 32'hDEADBEEF;
    regs[8'hFE] = 32'h11111111;
    regs[8'hFF] = 32'h22222222;
    regs[8'h00] = 32'h33333333;
    regs[8'h20] = 32'h01020304;
    regs[8'h21] = 32'hA0B0C0D0;

    vt[0] = '{8'h10, 6'd1,  8'h5A, 1'b0, 8'(5 + CS),   1'b1, (CS == 1) ? 8'h32 : 8'hEF};
    vt[1] = '{8'hFE, 6'd3,  8'h33, 1'b0, 8'(13 + CS),  1'b1, (CS == 1) ? 8'hFE : 8'h33};
    vt[2] = '{8'h42, 6'd0,  8'h77, 1'b0, 8'(1 + CS),   1'b1, 8'h42};
    vt[3] = '{8'h20, 6'd2,  8'h01, 1'b1, 8'(9 + CS),   1'b1, (CS == 1) ? 8'h24 : 8'hD0};
    vt[4] = '{8'h20, 6'd2,  8'h01, 1'b0, 8'(9 + CS),   1'b1, (CS == 1) ? 8'h24 : 8'hD0};
    vt[5] = '{8'hF0, 6'd63, 8'hC8, 1'b1, 8'(253 + CS), (CS == 0), 8'hC3};

    // Reset state
    step(); step(); step();
    chk("rst_ready", 32'(opReqReady), 32'h1);
    chk("rst_valid", 32'(opTxValid),  32'h0);
    chk("rst_sop",   32'(opTxSoP),    32'h0);
    chk("rst_eop",   32'(opTxEoP),    32'h0);
    chk("rst_data",  32'(opTxData),   32'h0);
    chk("rst_len",   32'(opTxLength), 32'h0);
    chk("rst_dest",  32'(opTxDestination), 32'h0);
    chk("rst_rdaddr", 32'(opRdAddress), 32'h0);
    chk("rst_src",   32'(opTxSource), 32'(LOC));
    ipReset = 1'b1;
    step();

    // Table vectors
    for (int v = 0; v < 6; v++) begin
      start_pkt($sformatf("vec%0d", v), vt[v].a, vt[v].c, vt[v].s, vt[v].rnd);
      finish_pkt($sformatf("vec%0d", v), vt[v].c, vt[v].s);
      if (cap_q.size() > 0) begin
        chk($sformatf("vec%0d_tbl_len", v), 32'(cap_q[0].len), 32'(vt[v].exp_len));
        if (vt[v].chk_last)
          chk($sformatf("vec%0d_tbl_last", v), 32'(cap_q[cap_q.size() - 1].data), 32'(vt[v].exp_last));
      end
      if (v == 1) begin
        chk("wrap_addr_fe", 32'(seen[8'hFE]), 32'h1);
        chk("wrap_addr_ff", 32'(seen[8'hFF]), 32'h1);
        chk("wrap_addr_00", 32'(seen[8'h00]), 32'h1);
      end
    end

    // Random bursts against the reference model
    for (int r = 0; r < 10; r++) begin
      logic [7:0] ra, rs;
      logic [5:0] rc;
      for (int j = 0; j < 256; j++) regs[j] = $urandom;
      ra = 8'($urandom_range(0, 255));
      rc = 6'($urandom_range(0, 63));
      rs = 8'($urandom_range(0, 255));
      start_pkt($sformatf("rnd%0d", r), ra, rc, rs, 1'($urandom_range(0, 1)));
      finish_pkt($sformatf("rnd%0d", r), rc, rs);
    end

    // Reset in the middle of a packet
    start_pkt("mid_rst", 8'h80, 6'd4, 8'h12, 1'b0);
    step(); step(); step();
    ipReset = 1'b0;
    step();
    chk("mid_rst_valid", 32'(opTxValid),  32'h0);
    chk("mid_rst_ready", 32'(opReqReady), 32'h1);
    chk("mid_rst_eop",   32'(opTxEoP),    32'h0);
    step(); step();
    ipReset = 1'b1;
    step();
    chk("mid_rst_no_eop", 32'(eop_cnt), 32'h0);
    chk("mid_rst_ready2", 32'(opReqReady), 32'h1);

    // Busy rejection, then a request right after EoP
    start_pkt("busy", 8'h30, 6'd2, 8'h11, 1'b0);
    step(); step();
    ipReqAddress = 8'h99;
    ipReqCount   = 6'd5;
    ipReqSource  = 8'h66;
    ipReqValid   = 1'b1;
    chk("busy_ready_low", 32'(opReqReady), 32'h0);
    step();
    ipReqValid   = 1'b0;
    finish_pkt("busy", 6'd2, 8'h11);
    start_pkt("b2b", 8'h44, 6'd1, 8'h22, 1'b0);
    finish_pkt("b2b", 6'd1, 8'h22);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_read_responder.md
Name: reg_read_responder

Overview:
- Return path of the UART register bridge.
- Accepts a register read request decoded from a host packet and fetches N consecutive 32-bit registers from the register file.
- Frames the results as one outgoing UART packet byte stream toward the UART packet transmitter.
- Complements the write/command decoder on the receive side.

Parameters:
LOCAL_ADDRESS, 8'h00, value placed in the packet Source field
BLOCK_WIDTH, 32, register width in bits; fixed at 32 (4 bytes per word)

Ports:
ipClk  in  1  system clock; all logic on rising edge
ipReset  in  1  synchronous, active-low reset
ipReqValid  in  1  read request strobe
opReqReady  out  1  high when idle and able to accept a request
ipReqAddress  in  8  first register address
ipReqCount  in  6  number of registers to read (0..63)
ipReqSource  in  8  requester ID; becomes packet Destination
opRdAddress  out  8  register file read address
ipRdData  in  32  register file read data, valid 1 cycle after opRdAddress
opTxSource  out  8  packet source (= LOCAL_ADDRESS)
opTxDestination  out  8  packet destination
opTxLength  out  8  packet payload length in bytes
opTxData  out  8  payload byte
opTxSoP  out  1  first byte of packet
opTxEoP  out  1  last byte of packet
opTxValid  out  1  byte valid
ipTxReady  in  1  downstream accepts byte when Valid and Ready both high

Behaviour:
- Reset (ipReset low at clock edge): state IDLE; opReqReady=1; opTxValid=0; opTxSoP=0; opTxEoP=0; opTxData=0; opTxLength=0; opTxDestination=0; opRdAddress=0; opTxSource=LOCAL_ADDRESS.
- Reset mid-packet: abandons the packet immediately, no EoP emitted.
- Request acceptance:
  - Accepted on an edge with ipReqValid & opReqReady.
  - Address, count and source are latched.
  - opReqReady drops the following cycle and stays low until the EoP byte is accepted.
- Length: opTxLength = 1 + 4*count, computed at acceptance and held constant for the whole packet.
- Packet layout:
  - Byte 0: start address, with SoP=1.
  - Then for each register k=0..count-1: data of register (addr+k) mod 256, MSB first.
  - EoP=1 on the final byte only.
- Count 0: single header byte with SoP=1 and EoP=1, Length=1; no register fetch.
- Address wrap: address counter is 8-bit and wraps 255 -> 0 within a burst.
- State machine:
  - IDLE -> HEADER on accept. opRdAddress is driven with the start address in the same cycle, so word 0 is prefetched.
  - HEADER: header byte presented. On handshake: -> DONE if count=0, else -> SEND. Data word 0 is captured into a 32-bit shift register.
  - SEND: presents shift[31:24]. Each handshake shifts left 8 bits.
    - After the 4th byte, if words remain: load next word, advance address, stay in SEND.
    - After the last byte of the last word: -> IDLE.
  - DONE: completes the header-only case and returns to IDLE.
- Prefetch: opRdAddress advances to the next word one cycle after each word load, so the next word is available before it is needed. No bubble between words while ipTxReady is held high.
- Throughput: one byte per cycle while ipTxReady=1. First byte appears 1 cycle after acceptance.
- Stall rule: while opTxValid=1 and ipTxReady=0, opTxData, opTxSoP, opTxEoP, opTxLength and opTxDestination hold stable.
- Back-to-back requests: a new request may be accepted in the cycle after EoP handshake (opReqReady=1 again).
- Request while busy: ipReqValid while opReqReady=0 is ignored; no queuing.

Optional Feature:
- Macro: READ_RESPONDER_CHECKSUM_EN.
- Defined:
  - One extra byte is appended after the last data byte: XOR of all preceding payload bytes, including the header.
  - That byte carries EoP. Length = 2 + 4*count (max 254).
  - Count 0 gives header + checksum, with checksum = address.
- Undefined: no checksum byte; Length = 1 + 4*count.

Test Plan:
- Reset: hold ipReset low 3 cycles mid-packet -> opTxValid=0, opReqReady=1 next cycle, no EoP seen.
- Single read: addr 0x10, count 1, reg[0x10]=0xDEADBEEF, ready always 1 -> bytes 10 DE AD BE EF on consecutive cycles; Length=5; SoP on byte0, EoP on byte4; Destination=ipReqSource.
- Burst with wrap: addr 0xFE, count 3, reg[0xFE]=0x11111111, reg[0xFF]=0x22222222, reg[0x00]=0x33333333 -> Length=13; words in that order; addresses 0xFE, 0xFF, 0x00 observed on opRdAddress.
- Backpressure: ipTxReady toggled pseudo-randomly during count 2 -> byte sequence identical to the unstalled run; outputs stable while stalled.
- Count 0: addr 0x42 -> one byte 0x42 with SoP=EoP=1, Length=1. With READ_RESPONDER_CHECKSUM_EN: bytes 42 42, Length=2.
- Busy rejection: second request pulsed mid-packet -> ignored. Request after EoP -> accepted; its header appears 1 cycle after acceptance.
